// File: rtl/bin_to_bcd_seq.sv
// Sequential 16-bit binary to 5-digit packed BCD converter (double-dabble, one bit per cycle).
// Define SIGNED_INPUT_EN to treat bin as two's complement and convert its magnitude.
module bin_to_bcd_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] bin,
    output logic        busy,
    output logic        done,
    output logic [19:0] bcd,
    output logic        sign
);

    // Handshake: start is sampled on any rising edge in IDLE or DONE and ignored in CONVERT;
    // done is a one-cycle pulse in which bcd/sign are newly valid, and they hold until the next done.
    typedef enum logic [1:0] {IDLE, CONVERT, DONE} state_t;

    state_t      state;
    logic [15:0] shift_q;
    logic [19:0] scratch_q;
    logic [3:0]  cnt_q;
    logic        pend_sign_q;

    logic        neg;
    logic [16:0] mag;
    logic [19:0] adj;
    logic [19:0] nxt_scratch;
    logic [15:0] nxt_shift;

    always_comb begin
`ifdef SIGNED_INPUT_EN
        neg = bin[15];
        mag = neg ? (17'h1_0000 - {1'b0, bin}) : {1'b0, bin};
`else
        neg = 1'b0;
        mag = {1'b0, bin};
`endif
    end

    always_comb begin
        adj = scratch_q;
        for (int d = 0; d < 5; d++) begin
            if (scratch_q[4*d +: 4] >= 4'd5)
                adj[4*d +: 4] = scratch_q[4*d +: 4] + 4'd3;
        end
        {nxt_scratch, nxt_shift} = {adj, shift_q} << 1;
    end

    assign busy = (state == CONVERT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            shift_q     <= 16'd0;
            scratch_q   <= 20'd0;
            cnt_q       <= 4'd0;
            pend_sign_q <= 1'b0;
            done        <= 1'b0;
            bcd         <= 20'd0;
            sign        <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        // mag[16] is always zero, so this also clears the scratch digits
                        {scratch_q, shift_q} <= {19'd0, mag};
                        cnt_q       <= 4'd0;
                        pend_sign_q <= neg;
                        state       <= CONVERT;
                    end else begin
                        state <= IDLE;
                    end
                end
                CONVERT: begin
                    scratch_q <= nxt_scratch;
                    shift_q   <= nxt_shift;
                    cnt_q     <= cnt_q + 4'd1;
                    if (cnt_q == 4'd15) begin
                        bcd   <= nxt_scratch;
                        sign  <= pend_sign_q;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed bench for bin_to_bcd_seq with a scoreboard of expected {sign, bcd} results.
// Expected values come from a decimal-division model of the converter.
module tb_bin_to_bcd_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] bin;
    logic        busy;
    logic        done;
    logic [19:0] bcd;
    logic        sign;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int acc_cyc  = 0;
    int t1, t2, t3;

    logic [20:0] exp_q[$];

    bin_to_bcd_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .bcd   (bcd),
        .sign  (sign)
    );

    // clock / reset block
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [20:0] model(input logic [15:0] v);
        logic        s;
        int          m;
        logic [19:0] r;
`ifdef SIGNED_INPUT_EN
        s = v[15];
        m = s ? (65536 - int'(v)) : int'(v);
`else
        s = 1'b0;
        m = int'(v);
`endif
        for (int d = 0; d < 5; d++) begin
            r[4*d +: 4] = 4'(m % 10);
            m = m / 10;
        end
        return {s, r};
    endfunction

    task automatic check_bit(input string tag, input logic obs, input logic expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, expv);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // driver: present start+bin for one accepting edge, then scramble bin
    task automatic launch(input logic [15:0] v);
        bin   = v;
        start = 1'b1;
        exp_q.push_back(model(v));
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        start   = 1'b0;
        bin     = 16'($urandom_range(0, 65535));
        check_bit("busy_after_accept", busy, 1'b1);
    endtask

    task automatic wait_done(input string tag, output int t);
        t = -1;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (done) begin
                t = cyc;
                break;
            end
            check_bit({tag, "_busy"}, busy, 1'b1);
        end
        check_bit({tag, "_done_seen"}, (t >= 0), 1'b1);
        check_bit({tag, "_busy_low_at_done"}, busy, 1'b0);
    endtask

    // scoreboard: compare each done pulse against the oldest expectation
    always @(negedge clk) begin
        if (rst_n) begin
            checks++;
            assert (!(busy && done)) else begin
                failures++;
                $error("FAIL busy_done_overlap observed=%0b%0b expected=not both", busy, done);
            end
            if (done) begin
                checks++;
                assert (exp_q.size() > 0) else begin
                    failures++;
                    $error("FAIL unexpected_done observed=done expected=no_done");
                end
                if (exp_q.size() > 0) begin
                    logic [20:0] e;
                    e = exp_q.pop_front();
                    checks++;
                    assert ({sign, bcd} === e) else begin
                        failures++;
                        $error("FAIL result observed=%0b/%05h expected=%0b/%05h", sign, bcd, e[20], e[19:0]);
                    end
                end
            end
        end
    end

    initial begin
        rst_n = 1'b1;
        start = 1'b0;
        bin   = 16'd0;
        #2 rst_n = 1'b0;
        #1;
        check_bit("reset_busy", busy, 1'b0);
        check_bit("reset_done", done, 1'b0);
        check_int("reset_bcd", int'(bcd), 0);
        check_bit("reset_sign", sign, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_bit("idle_no_start", busy, 1'b0);

        // basic conversion and latency
        launch(16'h3039);
        wait_done("conv_3039", t1);
        check_int("latency_3039", t1 - acc_cyc, 16);
        @(posedge clk);
        #1;
        check_bit("done_one_cycle", done, 1'b0);
        check_bit("back_to_idle", busy, 1'b0);

        launch(16'hFFFF);
        wait_done("conv_ffff", t1);
        launch(16'h8000);
        wait_done("conv_8000", t1);
        launch(16'h0000);
        wait_done("conv_0000", t1);
        launch(16'($urandom_range(0, 65535)));
        wait_done("conv_rand", t1);
        @(posedge clk);
        #1;

        // start held high: back-to-back with a 17 cycle period
        bin   = 16'h0457;
        start = 1'b1;
        repeat (3) exp_q.push_back(model(16'h0457));
        acc_cyc = cyc;
        wait_done("b2b_1", t1);
        check_int("b2b_first_latency", t1 - acc_cyc, 17);
        wait_done("b2b_2", t2);
        check_int("b2b_period_a", t2 - t1, 17);
        wait_done("b2b_3", t3);
        start = 1'b0;
        check_int("b2b_period_b", t3 - t2, 17);
        @(posedge clk);
        #1;
        check_bit("b2b_stop", busy, 1'b0);

        // start and bin changes during CONVERT are ignored
        launch(16'h3039);
        repeat (4) @(posedge clk);
        #1;
        bin   = 16'h0001;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done("ignore_start", t1);
        check_int("ignore_start_latency", t1 - acc_cyc, 16);
        @(posedge clk);
        #1;
        check_bit("ignore_start_no_rerun", busy, 1'b0);

        // asynchronous reset mid-conversion
        launch(16'h1234);
        repeat (7) @(posedge clk);
        #2;
        rst_n = 1'b0;
        void'(exp_q.pop_back());
        #1;
        check_bit("midrst_busy", busy, 1'b0);
        check_bit("midrst_done", done, 1'b0);
        check_int("midrst_bcd", int'(bcd), 0);
        check_bit("midrst_sign", sign, 1'b0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            if (busy || done) begin
                check_bit("post_reset_idle", 1'b1, 1'b0);
                break;
            end
        end
        launch(16'h0063);
        wait_done("conv_0063", t1);
        check_int("latency_0063", t1 - acc_cyc, 16);

        repeat (3) @(posedge clk);
        #1;
        check_int("queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
